// File: rtl/dmem_axil_bridge_pkg.sv
// -----------------------------------------------------------------------------
// dmem_axil_bridge_pkg
// Shared definitions for the data-memory to AXI4-Lite bridge:
//   state_t         bridge FSM states
//   RESP_*          AXI response codes
//   SZ_*            access size codes, same encoding as the memory-access
//                   stage's type field [1:0]
//   word_align()    clears the byte offset of a byte address
// -----------------------------------------------------------------------------
package dmem_axil_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_A,
      ST_RD_D,
      ST_WR_AW,
      ST_WR_B,
      ST_DONE
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/dmem_axil_bridge_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational helper for the bridge: detects misaligned half/word
// accesses and moves store data from lane 0 into its byte lane.
// Ports:
//   byte_off    in   2   address bits [1:0]
//   size        in   2   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   wdata       in  32   store data, unshifted
//   misaligned  out  1   half at odd address, or word not on a 4-byte boundary
//   wdata_lane  out 32   store data shifted left by 8*byte_off
// -----------------------------------------------------------------------------
module dmem_lane_align
   import dmem_axil_bridge_pkg::*;
(
   input  logic [1:0]  byte_off,
   input  logic [1:0]  size,
   input  logic [31:0] wdata,
   output logic        misaligned,
   output logic [31:0] wdata_lane
);

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      misaligned = 1'b0;
      case (size)
         SZ_HALF: misaligned = byte_off[0];
         SZ_WORD: misaligned = (byte_off != 2'b00);
         default: misaligned = 1'b0;
      endcase
   end

   assign wdata_lane = wdata << {byte_off, 3'b000};

endmodule

// File: rtl/dmem_axil_bridge.sv
// -----------------------------------------------------------------------------
// dmem_axil_bridge
// Converts the MEM stage's single-cycle data-memory request into one AXI4-Lite
// read or write, stalling the pipeline until the transaction completes. The
// completion cycle (DONE) releases the stall and presents the registered read
// word and a one-cycle fault flag (bus error or misalignment).
// Parameters:
//   FAULT_ON_MISALIGN  1: misaligned access faults with no bus traffic
//                      0: misaligned access is issued on the bus as-is
// Ports:
//   clk, rst                   clock; synchronous active-high reset
//   dmem_valid/addr/wdata/     request from the MEM stage (wen==0 means read)
//   wen/size
//   dmem_rdata                 last completed read word (registered)
//   dmem_stall                 hold the pipeline this cycle
//   dmem_fault                 pulse in the completion cycle on error
//   m_aw*/m_w*/m_b*/m_ar*/m_r* AXI4-Lite master channels
// -----------------------------------------------------------------------------
module dmem_axil_bridge
   import dmem_axil_bridge_pkg::*;
#(
   parameter bit FAULT_ON_MISALIGN = 1'b1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        dmem_valid,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   input  logic [3:0]  dmem_wen,
   input  logic [1:0]  dmem_size,
   output logic [31:0] dmem_rdata,
   output logic        dmem_stall,
   output logic        dmem_fault,
   output logic [31:0] m_awaddr,
   output logic        m_awvalid,
   input  logic        m_awready,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   output logic        m_wvalid,
   input  logic        m_wready,
   input  logic [1:0]  m_bresp,
   input  logic        m_bvalid,
   output logic        m_bready,
   output logic [31:0] m_araddr,
   output logic        m_arvalid,
   input  logic        m_arready,
   input  logic [31:0] m_rdata,
   input  logic [1:0]  m_rresp,
   input  logic        m_rvalid,
   output logic        m_rready
);

   state_t      state_q, state_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic        fault_q;
   logic [31:0] rdata_q;
   logic [31:0] awaddr_q, araddr_q, wdata_q;
   logic [3:0]  wstrb_q;
   logic        misaligned;
   logic [31:0] wdata_lane;
   logic        fault_misalign;
   logic        accept;

   dmem_lane_align u_lane_align (
      .byte_off   (dmem_addr[1:0]),
      .size       (dmem_size),
      .wdata      (dmem_wdata),
      .misaligned (misaligned),
      .wdata_lane (wdata_lane)
   );

   assign fault_misalign = misaligned && FAULT_ON_MISALIGN;
   assign accept         = (state_q == ST_IDLE) && dmem_valid;

   // Next state and channel valids/readies. Valids come straight from state
   // and the done flags, so they hold until their own handshake.
   always_comb begin
      state_d   = state_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      m_awvalid = 1'b0;
      m_wvalid  = 1'b0;
      m_bready  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (dmem_valid) begin
               if (fault_misalign)        state_d = ST_DONE;
               else if (dmem_wen != 4'h0) state_d = ST_WR_AW;
               else                       state_d = ST_RD_A;
            end
         end
         ST_RD_A: begin
            m_arvalid = 1'b1;
            if (m_arready) state_d = ST_RD_D;
         end
         ST_RD_D: begin
            m_rready = 1'b1;
            if (m_rvalid) state_d = ST_DONE;
         end
         ST_WR_AW: begin
            m_awvalid = !aw_done_q;
            m_wvalid  = !w_done_q;
            // A handshake in this cycle already counts toward leaving.
            aw_done_d = aw_done_q || m_awready;
            w_done_d  = w_done_q  || m_wready;
            if (aw_done_d && w_done_d) state_d = ST_WR_B;
         end
         ST_WR_B: begin
            m_bready = 1'b1;
            if (m_bvalid) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         fault_q   <= 1'b0;
         rdata_q   <= '0;
         awaddr_q  <= '0;
         araddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         state_q   <= state_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         if (accept) begin
            awaddr_q <= word_align(dmem_addr);
            araddr_q <= word_align(dmem_addr);
            wdata_q  <= wdata_lane;
            wstrb_q  <= dmem_wen;
            fault_q  <= fault_misalign;
         end
         // Read data is captured even on an error response.
         if (state_q == ST_RD_D && m_rvalid) begin
            rdata_q <= m_rdata;
            if (m_rresp != RESP_OKAY) fault_q <= 1'b1;
         end
         if (state_q == ST_WR_B && m_bvalid && m_bresp != RESP_OKAY) begin
            fault_q <= 1'b1;
         end
      end
   end

   assign m_awaddr   = awaddr_q;
   assign m_araddr   = araddr_q;
   assign m_wdata    = wdata_q;
   assign m_wstrb    = wstrb_q;
   assign dmem_rdata = rdata_q;
   assign dmem_fault = (state_q == ST_DONE) && fault_q;
   assign dmem_stall = dmem_valid && (state_q != ST_DONE);

endmodule

// File: tb/tb_dmem_axil_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_axil_bridge
// Drives MEM-stage requests into the bridge and plays an AXI4-Lite slave with
// per-channel ready/valid delays. Expected stall length, fault, read word and
// bus beats are derived from the access rules with plain arithmetic.
// A second instance with FAULT_ON_MISALIGN=0 covers the issue-as-is path.
// -----------------------------------------------------------------------------
module tb_dmem_axil_bridge;
   import dmem_axil_bridge_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // instance A: FAULT_ON_MISALIGN = 1
   logic        dmem_valid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_wen;
   logic [1:0]  dmem_size;
   logic        dmem_stall, dmem_fault;
   logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
   logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic        m_arvalid, m_arready, m_rvalid, m_rready;
   logic [3:0]  m_wstrb;
   logic [1:0]  m_bresp, m_rresp;

   // instance B: FAULT_ON_MISALIGN = 0
   logic        b_dmem_valid;
   logic [31:0] b_dmem_addr, b_dmem_rdata;
   logic [1:0]  b_dmem_size;
   logic        b_dmem_stall, b_dmem_fault;
   logic [31:0] b_awaddr, b_wdata, b_araddr, b_rdata;
   logic        b_awvalid, b_wvalid, b_bready, b_arvalid, b_arready, b_rvalid, b_rready;
   logic [3:0]  b_wstrb;

   dmem_axil_bridge #(.FAULT_ON_MISALIGN(1'b1)) u_dut (
      .clk(clk), .rst(rst),
      .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_wen(dmem_wen), .dmem_size(dmem_size), .dmem_rdata(dmem_rdata),
      .dmem_stall(dmem_stall), .dmem_fault(dmem_fault),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   dmem_axil_bridge #(.FAULT_ON_MISALIGN(1'b0)) u_dut_nofault (
      .clk(clk), .rst(rst),
      .dmem_valid(b_dmem_valid), .dmem_addr(b_dmem_addr), .dmem_wdata(32'h0),
      .dmem_wen(4'h0), .dmem_size(b_dmem_size), .dmem_rdata(b_dmem_rdata),
      .dmem_stall(b_dmem_stall), .dmem_fault(b_dmem_fault),
      .m_awaddr(b_awaddr), .m_awvalid(b_awvalid), .m_awready(1'b0),
      .m_wdata(b_wdata), .m_wstrb(b_wstrb), .m_wvalid(b_wvalid), .m_wready(1'b0),
      .m_bresp(2'b00), .m_bvalid(1'b0), .m_bready(b_bready),
      .m_araddr(b_araddr), .m_arvalid(b_arvalid), .m_arready(b_arready),
      .m_rdata(b_rdata), .m_rresp(2'b00), .m_rvalid(b_rvalid), .m_rready(b_rready)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // slave behaviour for the next access
   int          ar_delay, r_delay, aw_delay, w_delay, b_delay;
   logic [31:0] sl_rdata;
   logic [1:0]  sl_rresp, sl_bresp;

   // observations of the last access
   int          res_stalls, res_ar, res_aw, res_w, res_r, res_b, res_proto, res_valid_seen;
   logic        res_fault;
   logic [31:0] res_rdata, res_araddr, res_awaddr, res_wdata;
   logic [3:0]  res_wstrb;

   // reference: the word returned by the most recent completed read
   logic [31:0] model_rdata;

   task automatic set_slave(input int ar, input int r, input int aw, input int w, input int b,
                            input logic [31:0] rd, input logic [1:0] rr, input logic [1:0] br);
      ar_delay = ar; r_delay = r; aw_delay = aw; w_delay = w; b_delay = b;
      sl_rdata = rd; sl_rresp = rr; sl_bresp = br;
   endtask

   // Presents one request and acts as the slave until the completion cycle,
   // then spends the following (IDLE) cycle with dmem_valid low.
   task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wen, input logic [1:0] size);
      int   ar_w, r_w, aw_w, w_w, b_w, cyc;
      bit   done, r_pend, b_pend, b_armed, ar_open, aw_open, w_open;
      logic [31:0] ar_first, aw_first, w_first;
      res_stalls = 0; res_ar = 0; res_aw = 0; res_w = 0; res_r = 0; res_b = 0;
      res_proto = 0; res_valid_seen = 0; res_fault = 1'bx; res_rdata = 'x;
      res_araddr = 'x; res_awaddr = 'x; res_wdata = 'x; res_wstrb = 'x;
      ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0; cyc = 0;
      done = 0; r_pend = 0; b_pend = 0; b_armed = 0; ar_open = 0; aw_open = 0; w_open = 0;
      ar_first = '0; aw_first = '0; w_first = '0;
      dmem_valid = 1'b1; dmem_addr = addr; dmem_wdata = wdata; dmem_wen = wen; dmem_size = size;
      #1;
      while (!done && cyc < 200) begin
         if (m_arvalid || m_awvalid || m_wvalid) res_valid_seen++;
         if (!dmem_stall) begin
            done = 1;
            res_fault = dmem_fault;
            res_rdata = dmem_rdata;
            m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_bvalid = 0;
         end else begin
            res_stalls++;
            // responses first, so a new request handshake starts them next cycle
            if (r_pend && r_w >= r_delay) begin
               m_rvalid = 1; m_rdata = sl_rdata; m_rresp = sl_rresp;
               if (m_rready) begin res_r++; r_pend = 0; end
            end else begin
               m_rvalid = 0; m_rdata = $urandom; m_rresp = 2'($urandom);
               if (r_pend) r_w++;
            end
            if (b_pend && b_w >= b_delay) begin
               m_bvalid = 1; m_bresp = sl_bresp;
               if (m_bready) begin res_b++; b_pend = 0; end
            end else begin
               m_bvalid = 0; m_bresp = 2'($urandom);
               if (b_pend) b_w++;
            end
            m_arready = 0;
            if (m_arvalid) begin
               if (ar_open && m_araddr !== ar_first) res_proto++;
               if (!ar_open) begin ar_open = 1; ar_first = m_araddr; end
               if (ar_w >= ar_delay) begin
                  m_arready = 1; res_ar++; res_araddr = m_araddr;
                  ar_open = 0; ar_w = 0; r_pend = 1; r_w = 0;
               end else ar_w++;
            end else if (ar_open) res_proto++;
            m_awready = 0;
            if (m_awvalid) begin
               if (aw_open && m_awaddr !== aw_first) res_proto++;
               if (!aw_open) begin aw_open = 1; aw_first = m_awaddr; end
               if (aw_w >= aw_delay) begin
                  m_awready = 1; res_aw++; res_awaddr = m_awaddr; aw_open = 0; aw_w = 0;
               end else aw_w++;
            end else if (aw_open) res_proto++;
            m_wready = 0;
            if (m_wvalid) begin
               if (w_open && m_wdata !== w_first) res_proto++;
               if (!w_open) begin w_open = 1; w_first = m_wdata; end
               if (w_w >= w_delay) begin
                  m_wready = 1; res_w++; res_wdata = m_wdata; res_wstrb = m_wstrb;
                  w_open = 0; w_w = 0;
               end else w_w++;
            end else if (w_open) res_proto++;
            if (!b_armed && res_aw > 0 && res_w > 0) begin
               b_armed = 1; b_pend = 1; b_w = 0;
            end
         end
         @(negedge clk);
         cyc++;
      end
      n_tests++;
      if (!done) begin
         n_fail++;
         $display("FAIL access_timeout: addr %h got no completion, required completion within 200 cycles", addr);
      end
      dmem_valid = 1'b0;
      m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_bvalid = 0;
      if (done) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_handshake: got %b required 00000",
                  {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready});
      end
      n_tests++;
      if ({m_awaddr, m_araddr, m_wdata, m_wstrb} !== 100'h0) begin
         n_fail++;
         $display("FAIL reset_bus_regs: got aw %h ar %h w %h s %h required all zero",
                  m_awaddr, m_araddr, m_wdata, m_wstrb);
      end
      n_tests++;
      if ({dmem_rdata, dmem_fault, dmem_stall} !== 34'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdata %h fault %b stall %b required 0/0/0",
                  dmem_rdata, dmem_fault, dmem_stall);
      end
      rst = 1'b0;
      model_rdata = 32'h0;
      @(negedge clk);
   endtask

   task automatic test_word_read();
      set_slave(0, 0, 0, 0, 0, 32'hDEAD_BEEF, RESP_OKAY, RESP_OKAY);
      access(32'h8000_0004, 32'h0, 4'h0, SZ_WORD);
      model_rdata = 32'hDEAD_BEEF;
      n_tests++;
      if (res_araddr !== 32'h8000_0004) begin
         n_fail++; $display("FAIL read_araddr: got %h required 80000004", res_araddr);
      end
      n_tests++;
      if (res_stalls !== 3) begin
         n_fail++; $display("FAIL read_stall_cycles: got %0d required 3", res_stalls);
      end
      n_tests++;
      if (res_rdata !== model_rdata || res_fault !== 1'b0) begin
         n_fail++; $display("FAIL read_data: got %h fault %b required %h fault 0", res_rdata, res_fault, model_rdata);
      end
   endtask

   task automatic test_byte_store();
      set_slave(0, 0, 0, 0, 0, 32'h0, RESP_OKAY, RESP_OKAY);
      access(32'h1000_0002, 32'h0000_00AB, 4'b0100, SZ_BYTE);
      n_tests++;
      if (res_wdata !== 32'h00AB_0000 || res_wstrb !== 4'b0100) begin
         n_fail++; $display("FAIL store_lane: got wdata %h wstrb %b required 00ab0000 0100", res_wdata, res_wstrb);
      end
      n_tests++;
      if (res_awaddr !== 32'h1000_0000) begin
         n_fail++; $display("FAIL store_awaddr: got %h required 10000000", res_awaddr);
      end
      n_tests++;
      if (res_stalls !== 3 || res_fault !== 1'b0 || res_rdata !== model_rdata) begin
         n_fail++; $display("FAIL store_done: got stalls %0d fault %b rdata %h required 3 0 %h",
                            res_stalls, res_fault, res_rdata, model_rdata);
      end
   endtask

   task automatic test_slow_write();
      // AW accepted immediately, W three cycles later, B two cycles late
      set_slave(0, 0, 0, 3, 2, 32'h0, RESP_OKAY, RESP_OKAY);
      access(32'h2000_0008, 32'hA5A5_0F0F, 4'hF, SZ_WORD);
      n_tests++;
      if (res_aw !== 1 || res_w !== 1 || res_b !== 1 || res_proto !== 0) begin
         n_fail++; $display("FAIL slow_write_beats: got aw %0d w %0d b %0d proto %0d required 1 1 1 0",
                            res_aw, res_w, res_b, res_proto);
      end
      n_tests++;
      if (res_stalls !== 8 || res_fault !== 1'b0) begin
         n_fail++; $display("FAIL slow_write_stalls: got %0d fault %b required 8 fault 0", res_stalls, res_fault);
      end
   endtask

   task automatic test_read_slverr();
      set_slave(0, 0, 0, 0, 0, 32'h1234_5678, RESP_SLVERR, RESP_OKAY);
      access(32'h0000_0010, 32'h0, 4'h0, SZ_WORD);
      model_rdata = 32'h1234_5678;
      n_tests++;
      if (res_fault !== 1'b1 || res_rdata !== model_rdata) begin
         n_fail++; $display("FAIL slverr_done: got fault %b rdata %h required 1 %h", res_fault, res_rdata, model_rdata);
      end
      // access() returns in the cycle after completion: the pulse must be gone
      n_tests++;
      if (dmem_fault !== 1'b0) begin
         n_fail++; $display("FAIL slverr_pulse_width: got fault %b after DONE required 0", dmem_fault);
      end
   endtask

   task automatic test_misaligned();
      set_slave(0, 0, 0, 0, 0, 32'hFFFF_FFFF, RESP_OKAY, RESP_OKAY);
      access(32'h3000_0003, 32'h0, 4'h0, SZ_HALF);
      n_tests++;
      if (res_stalls !== 1 || res_fault !== 1'b1) begin
         n_fail++; $display("FAIL misalign_fault: got stalls %0d fault %b required 1 1", res_stalls, res_fault);
      end
      n_tests++;
      if (res_valid_seen !== 0 || res_rdata !== model_rdata) begin
         n_fail++; $display("FAIL misalign_no_bus: got valid cycles %0d rdata %h required 0 %h",
                            res_valid_seen, res_rdata, model_rdata);
      end
   endtask

   task automatic test_misalign_issue();
      int cyc;
      bit ar_seen, r_pend;
      logic [31:0] ar_addr;
      cyc = 0; ar_seen = 0; r_pend = 0; ar_addr = '0;
      b_dmem_valid = 1'b1; b_dmem_addr = 32'h3000_0003; b_dmem_size = SZ_HALF;
      #1;
      while (b_dmem_stall && cyc < 20) begin
         b_rvalid  = r_pend;
         b_rdata   = 32'hCAFE_F00D;
         if (r_pend && b_rready) r_pend = 0;
         b_arready = b_arvalid;
         if (b_arvalid) begin ar_seen = 1; ar_addr = b_araddr; r_pend = 1; end
         @(negedge clk);
         cyc++;
      end
      n_tests++;
      if (ar_seen !== 1'b1 || ar_addr !== 32'h3000_0000) begin
         n_fail++; $display("FAIL nofault_issue: got ar %b araddr %h required 1 30000000", ar_seen, ar_addr);
      end
      n_tests++;
      if (cyc !== 3 || b_dmem_fault !== 1'b0 || b_dmem_rdata !== 32'hCAFE_F00D) begin
         n_fail++; $display("FAIL nofault_done: got stalls %0d fault %b rdata %h required 3 0 cafef00d",
                            cyc, b_dmem_fault, b_dmem_rdata);
      end
      b_dmem_valid = 1'b0; b_arready = 1'b0; b_rvalid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      dmem_valid = 1'b1; dmem_addr = 32'h4000_0000; dmem_wen = 4'h0; dmem_size = SZ_WORD;
      @(negedge clk);
      n_tests++;
      if (m_arvalid !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_arvalid: got %b required 1", m_arvalid);
      end
      m_arready = 1'b1;
      @(negedge clk);
      m_arready = 1'b0; m_rvalid = 1'b0;
      n_tests++;
      if (m_rready !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_rready: got %b required 1", m_rready);
      end
      rst = 1'b1; dmem_valid = 1'b0;
      @(negedge clk);
      model_rdata = 32'h0;
      n_tests++;
      if ({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready} !== 5'b0 ||
          dmem_rdata !== model_rdata || dmem_fault !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_state: got hs %b rdata %h fault %b required 00000 0 0",
                            {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, dmem_rdata, dmem_fault);
      end
      rst = 1'b0;
      @(negedge clk);
      set_slave(0, 0, 0, 0, 0, 32'h0BAD_F00D, RESP_OKAY, RESP_OKAY);
      access(32'h4000_0000, 32'h0, 4'h0, SZ_WORD);
      model_rdata = 32'h0BAD_F00D;
      n_tests++;
      if (res_stalls !== 3 || res_rdata !== model_rdata) begin
         n_fail++; $display("FAIL rstmid_recover: got stalls %0d rdata %h required 3 %h", res_stalls, res_rdata, model_rdata);
      end
   endtask

   task automatic test_random_back_to_back();
      logic [31:0] addr, wdata, exp_wdata;
      logic [3:0]  wen;
      logic [1:0]  size;
      bit          mis, is_rd, is_wr;
      int          exp_stalls;
      logic        exp_fault;
      for (int i = 0; i < 40; i++) begin
         addr  = $urandom;
         wdata = $urandom;
         size  = 2'($urandom_range(0, 2));
         wen   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                   ($urandom_range(0, 3) == 0) ? RESP_SLVERR : RESP_OKAY,
                   ($urandom_range(0, 3) == 0) ? RESP_SLVERR : RESP_OKAY);
         mis   = (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00);
         is_wr = !mis && (wen != 4'h0);
         is_rd = !mis && (wen == 4'h0);
         exp_wdata = wdata << (8 * addr[1:0]);
         access(addr, wdata, wen, size);
         if (mis) begin
            exp_stalls = 1; exp_fault = 1'b1;
         end else if (is_wr) begin
            exp_stalls = 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay;
            exp_fault  = (sl_bresp != RESP_OKAY);
         end else begin
            exp_stalls  = 3 + ar_delay + r_delay;
            exp_fault   = (sl_rresp != RESP_OKAY);
            model_rdata = sl_rdata;
         end
         n_tests++;
         if (res_stalls !== exp_stalls || res_fault !== exp_fault || res_rdata !== model_rdata) begin
            n_fail++; $display("FAIL rand%0d_done: got stalls %0d fault %b rdata %h required %0d %b %h",
                               i, res_stalls, res_fault, res_rdata, exp_stalls, exp_fault, model_rdata);
         end
         n_tests++;
         if (res_ar !== int'(is_rd) || res_aw !== int'(is_wr) || res_w !== int'(is_wr) || res_proto !== 0) begin
            n_fail++; $display("FAIL rand%0d_beats: got ar %0d aw %0d w %0d proto %0d required %0d %0d %0d 0",
                               i, res_ar, res_aw, res_w, res_proto, is_rd, is_wr, is_wr);
         end
         if (is_rd) begin
            n_tests++;
            if (res_araddr !== {addr[31:2], 2'b00}) begin
               n_fail++; $display("FAIL rand%0d_araddr: got %h required %h", i, res_araddr, {addr[31:2], 2'b00});
            end
         end
         if (is_wr) begin
            n_tests++;
            if (res_awaddr !== {addr[31:2], 2'b00} || res_wdata !== exp_wdata || res_wstrb !== wen) begin
               n_fail++; $display("FAIL rand%0d_write: got %h %h %b required %h %h %b", i,
                                  res_awaddr, res_wdata, res_wstrb, {addr[31:2], 2'b00}, exp_wdata, wen);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      dmem_valid = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_wen = '0; dmem_size = '0;
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0;
      m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
      b_dmem_valid = 1'b0; b_dmem_addr = '0; b_dmem_size = '0;
      b_arready = 1'b0; b_rvalid = 1'b0; b_rdata = '0;
      model_rdata = '0;
      test_reset();
      test_word_read();
      test_byte_store();
      test_slow_write();
      test_read_slverr();
      test_misaligned();
      test_misalign_issue();
      test_reset_mid();
      test_random_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, required finish before 500000 time units");
      $fatal(1);
   end

endmodule

// File: doc/dmem_axil_bridge.md
# dmem_axil_bridge

Data-memory bus bridge that sits directly downstream of the memory-access stage. It converts the stage's single-cycle data-memory request (address, write data, byte-enable write strobe, valid) into AXI4-Lite read or write transactions. While a transaction is outstanding it stalls the pipeline, then returns the full read word for lane extraction upstream. It also aligns write data to byte lanes and flags misaligned accesses and bus errors.

## Interface
- `FAULT_ON_MISALIGN`, default 1: 1 = a misaligned access completes with a fault and no bus traffic; 0 = it is issued as-is.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `dmem_valid`  in  1  request present in MEM stage (read or write).
- `dmem_addr`  in  32  byte address.
- `dmem_wdata`  in  32  store data, unshifted (lane 0 holds the byte/half).
- `dmem_wen`  in  4  byte strobe; nonzero = write, 0 = read.
- `dmem_size`  in  2  00 byte, 01 half, 10 word; driven from memory type [1:0].
- `dmem_rdata`  out  32  full aligned read word (registered).
- `dmem_stall`  out  1  hold the pipeline this cycle.
- `dmem_fault`  out  1  one-cycle pulse in the completion cycle on error or misalignment.
- `m_awaddr/m_awvalid/m_awready`  out/out/in  32/1/1  write address channel.
- `m_wdata/m_wstrb/m_wvalid/m_wready`  out/out/out/in  32/4/1/1  write data channel.
- `m_bresp/m_bvalid/m_bready`  in/in/out  2/1/1  write response channel.
- `m_araddr/m_arvalid/m_arready`  out/out/in  32/1/1  read address channel.
- `m_rdata/m_rresp/m_rvalid/m_rready`  in/in/in/out  32/2/1/1  read data channel.

## Operation
- FSM states:
  - IDLE.
  - RD_A: arvalid=1.
  - RD_D: rready=1.
  - WR_AW: awvalid and/or wvalid, each until its own handshake, tracked by aw_done/w_done flags.
  - WR_B: bready=1.
  - DONE.
- IDLE with dmem_valid:
  - misaligned (half with addr[0]=1, or word with addr[1:0]≠0) and FAULT_ON_MISALIGN=1 → DONE with fault latched.
  - else wen≠0 → WR_AW; wen=0 → RD_A.
- Addresses: awaddr/araddr = {addr[31:2],2'b00}, latched on leaving IDLE.
- Write data and strobe: wdata = dmem_wdata << (8·addr[1:0]); wstrb = dmem_wen, passed through. Both are latched on leaving IDLE.
- Channel handshakes:
  - RD_A → RD_D on arvalid&arready.
  - RD_D → DONE on rvalid (rdata captured into dmem_rdata).
  - WR_AW → WR_B when both aw_done and w_done (same-cycle handshakes count).
  - WR_B → DONE on bvalid.
- rresp/bresp ≠ 00 → fault latched; read data is still captured.
- DONE: dmem_stall=0, dmem_fault=latched fault; → IDLE unconditionally next cycle. The pipeline advances at this edge.
- dmem_stall = dmem_valid && state≠DONE (combinational).
- dmem_rdata holds its value until the next read completes; writes do not alter it.
- Bus valids, once asserted, stay asserted until their handshake; address and data stay stable.

## Timing
- Reset values:
  - state=IDLE.
  - all m_*valid and m_*ready = 0.
  - awaddr/araddr/wdata/wstrb = 0.
  - dmem_rdata = 0, dmem_fault = 0.
- Reset mid-transaction: abandon it, return to IDLE next cycle. The bus slave is reset by the same rst.
- Zero-wait slave, read:
  - c0: IDLE, stall=1.
  - c1: AR handshake.
  - c2: R handshake.
  - c3: DONE, stall=0, rdata valid.
  - Total 3 stall cycles.
- Zero-wait slave, write: same shape, with AW+W in c1 and B in c2.
- Misaligned with FAULT_ON_MISALIGN=1: c0 IDLE stall=1, c1 DONE fault=1; no bus valid ever asserted.
- Back-to-back requests: the request after DONE starts in the following IDLE cycle. Minimum one IDLE cycle between transactions.
- dmem_valid dropping while busy is illegal; the transaction completes regardless.

## Structure
- Shared package:
  - state enum.
  - AXI resp constants OKAY=2'b00, SLVERR=2'b10.
  - size constants SZ_BYTE/SZ_HALF/SZ_WORD, matching the memory-access stage's type encoding.
- One sub-module, `dmem_lane_align`: combinational misalign detect plus wdata lane shift; the FSM stays in the top.

## Test plan
- Word read 0x8000_0004, zero-wait slave returns 0xDEADBEEF:
  - araddr=0x8000_0004.
  - stall high exactly 3 cycles.
  - dmem_rdata=0xDEADBEEF in the DONE cycle.
  - fault=0.
- Byte store, wdata=0x0000_00AB, wen=4'b0100, addr=0x...02 → wdata=0x00AB_0000, wstrb=0100, awaddr=0x...00.
- Write with awready 3 cycles before wready, then bvalid 2 cycles late:
  - each valid held until its own handshake.
  - DONE only after B.
  - no duplicate AW.
- Read with rresp=SLVERR, rdata=0x1234_5678 → fault pulse 1 cycle in DONE, rdata=0x1234_5678.
- Half load at addr 0x...03 → 1 stall cycle, fault=1, no arvalid; with FAULT_ON_MISALIGN=0, the bus read is issued instead.
- rst asserted in RD_D with rvalid low → next cycle IDLE, all valids 0, dmem_rdata=0, fault=0.
